// File: rtl/bnn_fc_argmax_pkg.sv
// Shared BNN definitions for the FC argmax stage: default sizing,
// FSM state encoding and the running-max reset constant.
package bnn_fc_argmax_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DW_DEF          = 13;
  localparam int CW_DEF          = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Most negative (DW+1)-bit value, so the first real score always wins.
  function automatic logic signed [31:0] max_init(input int dw);
    max_init = -(32'sd1 <<< dw);
  endfunction

endpackage

// File: rtl/bnn_fc_argmax_max_cmp.sv
// Signed compare-and-select for the argmax chain. A candidate replaces
// the current best only when strictly greater, so ties keep the lower index.
module bnn_max_cmp #(
  parameter int DW = 13,
  parameter int CW = 4
) (
  input  logic signed [DW:0]   iScore,
  input  logic        [CW-1:0] iIndex,
  input  logic signed [DW:0]   iMax,
  input  logic        [CW-1:0] iMaxIdx,
  output logic signed [DW:0]   oMax,
  output logic        [CW-1:0] oIdx
);

  // Strict greater-than select
  always_comb begin
    oMax = iMax;
    oIdx = iMaxIdx;
    if (iScore > iMax) begin
      oMax = iScore;
      oIdx = iIndex;
    end
  end

endmodule

// File: rtl/bnn_fc_argmax.sv
// Argmax over the FC layer outputs of a BNN: collects NUM_CLASSES signed
// neuron results in order and reports the index and score of the largest.
// Optional feature: define BNN_ARGMAX_BIAS_EN to add a per-neuron bias
// input (iBIAS) to each score before comparison.
//
//  state   | meaning
//  IDLE    | waiting for iSTART, no beats accepted
//  COLLECT | accepting beats, oREADY/oBUSY high
//  DONE    | one cycle, oDONE high, result registered
module bnn_fc_argmax
  import bnn_fc_argmax_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DW          = DW_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iSTART,
  input  logic                iVALID,
  input  logic signed [DW-1:0] iDATA,
`ifdef BNN_ARGMAX_BIAS_EN
  input  logic signed [DW-1:0] iBIAS,
`endif
  output logic                oREADY,
  output logic                oBUSY,
  output logic                oDONE,
  output logic        [CW-1:0] oCLASS,
  output logic signed [DW:0]   oSCORE
);

  localparam logic signed [DW:0]   MAX_INIT = (DW+1)'(max_init(DW));
  localparam logic        [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);

  logic        [1:0]    stateR;
  logic        [CW-1:0] cntR;
  logic signed [DW:0]   maxR;
  logic        [CW-1:0] idxR;
  logic signed [DW:0]   score;
  logic signed [DW:0]   nxtMax;
  logic        [CW-1:0] nxtIdx;

  // Widen the beat (and bias) to DW+1 bits so the sum cannot overflow
  always_comb begin
    score = {iDATA[DW-1], iDATA};
`ifdef BNN_ARGMAX_BIAS_EN
    score = {iDATA[DW-1], iDATA} + {iBIAS[DW-1], iBIAS};
`endif
  end

  bnn_max_cmp #(
    .DW(DW),
    .CW(CW)
  ) uMaxCmp (
    .iScore (score),
    .iIndex (cntR),
    .iMax   (maxR),
    .iMaxIdx(idxR),
    .oMax   (nxtMax),
    .oIdx   (nxtIdx)
  );

  // Sequencing FSM; iSTART from any state (re)initialises COLLECT and
  // wins over a same-cycle beat
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stateR <= ST_IDLE;
      cntR   <= '0;
      maxR   <= '0;
      idxR   <= '0;
      oREADY <= 1'b0;
      oDONE  <= 1'b0;
      oCLASS <= '0;
      oSCORE <= '0;
    end else begin
      oDONE <= 1'b0;
      if (iSTART) begin
        stateR <= ST_COLLECT;
        cntR   <= '0;
        maxR   <= MAX_INIT;
        idxR   <= '0;
        oREADY <= 1'b1;
      end else begin
        case (stateR)
          ST_COLLECT: begin
            if (iVALID) begin
              maxR <= nxtMax;
              idxR <= nxtIdx;
              cntR <= cntR + CW'(1);
              if (cntR == LAST_IDX) begin
                stateR <= ST_DONE;
                oREADY <= 1'b0;
                oDONE  <= 1'b1;
                oCLASS <= nxtIdx;
                oSCORE <= nxtMax;
              end
            end
          end
          ST_DONE: begin
            stateR <= ST_IDLE;
          end
          default: begin
            stateR <= ST_IDLE;
            oREADY <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oBUSY = (stateR == ST_COLLECT);

endmodule

// File: tb/tb_bnn_fc_argmax.sv
// Self-checking bench for bnn_fc_argmax with a plain argmax reference model.
// Define BNN_ARGMAX_BIAS_EN to exercise the bias input as well.
module tb_bnn_fc_argmax;

  localparam int NC = 10;
  localparam int DW = 13;
  localparam int CW = 4;
`ifdef BNN_ARGMAX_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  typedef int vec_t[NC];

  logic                 iCLK;
  logic                 iRST_n;
  logic                 iSTART;
  logic                 iVALID;
  logic signed [DW-1:0] iDATA;
`ifdef BNN_ARGMAX_BIAS_EN
  logic signed [DW-1:0] iBIAS;
`endif
  logic                 oREADY;
  logic                 oBUSY;
  logic                 oDONE;
  logic        [CW-1:0] oCLASS;
  logic signed [DW:0]   oSCORE;

  int checks   = 0;
  int failures = 0;
  int doneCnt  = 0;

  bnn_fc_argmax #(.NUM_CLASSES(NC), .DW(DW), .CW(CW)) dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .iSTART(iSTART),
    .iVALID(iVALID),
    .iDATA (iDATA),
`ifdef BNN_ARGMAX_BIAS_EN
    .iBIAS (iBIAS),
`endif
    .oREADY(oREADY),
    .oBUSY (oBUSY),
    .oDONE (oDONE),
    .oCLASS(oCLASS),
    .oSCORE(oSCORE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (oDONE === 1'b1) doneCnt++;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Reference: first highest score wins.
  function automatic void ref_argmax(input vec_t d, input vec_t b, output int idx, output int sc);
    int s;
    idx = 0;
    sc  = d[0] + (BIAS_ON ? b[0] : 0);
    for (int i = 1; i < NC; i++) begin
      s = d[i] + (BIAS_ON ? b[i] : 0);
      if (s > sc) begin
        sc  = s;
        idx = i;
      end
    end
  endfunction

  task automatic check_outputs_zero(input string nm);
    checks++;
    if (oREADY !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oCLASS !== '0 || oSCORE !== '0) begin
      failures++;
      $display("FAIL %s: got ready=%b busy=%b done=%b class=%0d score=%0d, want all zero",
               nm, oREADY, oBUSY, oDONE, oCLASS, oSCORE);
    end
  endtask

  // Feeds one inference. Ends one cycle after oDONE, having checked latency,
  // result, pulse width and hold. With startInDone, iSTART is raised in DONE.
  task automatic run_seq(input vec_t d, input vec_t b, input bit doStart, input int stall,
                         input bit randStall, input bit startInDone, input string nm);
    int expIdx, expSc, d0, n;
    logic signed [DW:0] es;
    logic [CW-1:0] ec;
    ref_argmax(d, b, expIdx, expSc);
    es = expSc[DW:0];
    ec = expIdx[CW-1:0];
    d0 = doneCnt;
    if (doStart) begin
      iSTART = 1'b1;
      step();
      iSTART = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (oREADY !== 1'b1 || oBUSY !== 1'b1) begin
        failures++;
        $display("FAIL %s ready beat %0d: got ready=%b busy=%b, want 1/1", nm, i, oREADY, oBUSY);
      end
      iVALID = 1'b1;
      iDATA  = d[i][DW-1:0];
`ifdef BNN_ARGMAX_BIAS_EN
      iBIAS  = b[i][DW-1:0];
`endif
      step();
      iVALID = 1'b0;
      iDATA  = $urandom;
      if (i < NC - 1) begin
        n = randStall ? $urandom_range(0, stall) : stall;
        for (int k = 0; k < n; k++) begin
          step();
          checks++;
          if (oREADY !== 1'b1 || oDONE !== 1'b0) begin
            failures++;
            $display("FAIL %s stall: got ready=%b done=%b, want 1/0", nm, oREADY, oDONE);
          end
        end
      end
    end
    checks++;
    if (oDONE !== 1'b1 || oREADY !== 1'b0 || oBUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s done latency: got done=%b ready=%b busy=%b, want 1/0/0", nm, oDONE, oREADY, oBUSY);
    end
    checks++;
    if (oCLASS !== ec || oSCORE !== es) begin
      failures++;
      $display("FAIL %s result: got class=%0d score=%0d, want class=%0d score=%0d",
               nm, oCLASS, oSCORE, ec, es);
    end
    if (startInDone) iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    checks++;
    if (oDONE !== 1'b0 || doneCnt - d0 != 1) begin
      failures++;
      $display("FAIL %s done pulse: got done=%b pulses=%0d, want 0 and 1", nm, oDONE, doneCnt - d0);
    end
    checks++;
    if (oCLASS !== ec || oSCORE !== es) begin
      failures++;
      $display("FAIL %s hold: got class=%0d score=%0d, want class=%0d score=%0d", nm, oCLASS, oSCORE, ec, es);
    end
    checks++;
    if (oREADY !== startInDone || oBUSY !== startInDone) begin
      failures++;
      $display("FAIL %s after done: got ready=%b busy=%b, want %b", nm, oREADY, oBUSY, startInDone);
    end
  endtask

  function automatic vec_t zero_vec();
    vec_t z;
    foreach (z[i]) z[i] = 0;
    return z;
  endfunction

  function automatic vec_t basic_vec();
    vec_t v;
    v = '{5, -3, 40, 40, 7, 0, -48, 12, 1, 2};
    return v;
  endfunction

  task automatic test_reset();
    iRST_n = 1'b0; iSTART = 1'b0; iVALID = 1'b0; iDATA = '0;
`ifdef BNN_ARGMAX_BIAS_EN
    iBIAS = '0;
`endif
    #3;
    check_outputs_zero("reset_async");
    step(); step();
    iRST_n = 1'b1;
    step(); step();
    check_outputs_zero("reset_idle");
  endtask

  task automatic test_basic();
    run_seq(basic_vec(), zero_vec(), 1'b1, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_all_negative();
    vec_t v;
    foreach (v[i]) v[i] = -2592;
    run_seq(v, zero_vec(), 1'b1, 0, 1'b0, 1'b0, "all_negative");
  endtask

  task automatic test_stalls();
    run_seq(basic_vec(), zero_vec(), 1'b1, 3, 1'b0, 1'b0, "stalls");
  endtask

  task automatic test_abort();
    vec_t v;
    int d0;
    d0 = doneCnt;
    iSTART = 1'b1; step(); iSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iVALID = 1'b1; iDATA = DW'(i + 1); step();
    end
    iSTART = 1'b1; iVALID = 1'b1; iDATA = DW'(500);
    step();
    iSTART = 1'b0; iVALID = 1'b0;
    foreach (v[i]) v[i] = $urandom_range(0, 99) - 50;
    v[9] = 100;
    run_seq(v, zero_vec(), 1'b0, 0, 1'b0, 1'b0, "abort");
    checks++;
    if (doneCnt - d0 != 1 || oCLASS !== 4'd9) begin
      failures++;
      $display("FAIL abort total: got pulses=%0d class=%0d, want 1 and 9", doneCnt - d0, oCLASS);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    iSTART = 1'b1; step(); iSTART = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iVALID = 1'b1; iDATA = DW'(300 + i); step();
    end
    iVALID = 1'b0;
    #2 iRST_n = 1'b0;
    #1 check_outputs_zero("reset_mid_async");
    step();
    iRST_n = 1'b1;
    d0 = doneCnt;
    iVALID = 1'b1; iDATA = DW'(4000);
    for (int i = 0; i < 12; i++) step();
    iVALID = 1'b0;
    checks++;
    if (oREADY !== 1'b0 || oBUSY !== 1'b0 || doneCnt != d0 || oCLASS !== '0 || oSCORE !== '0) begin
      failures++;
      $display("FAIL reset_mid ignore: got ready=%b busy=%b pulses=%0d class=%0d score=%0d, want all 0",
               oREADY, oBUSY, doneCnt - d0, oCLASS, oSCORE);
    end
    run_seq(basic_vec(), zero_vec(), 1'b1, 1, 1'b1, 1'b0, "reset_mid_restart");
  endtask

`ifdef BNN_ARGMAX_BIAS_EN
  task automatic test_bias();
    vec_t v, b;
    foreach (v[i]) begin v[i] = 2591; b[i] = 0; end
    v[0] = 2592; b[0] = 2592;
    run_seq(v, b, 1'b1, 0, 1'b0, 1'b0, "bias");
    checks++;
    if (oSCORE !== 14'sd5184 || oCLASS !== 4'd0) begin
      failures++;
      $display("FAIL bias overflow: got class=%0d score=%0d, want 0 and 5184", oCLASS, oSCORE);
    end
  endtask
`endif

  task automatic test_back_to_back();
    vec_t a, c;
    foreach (a[i]) begin a[i] = $urandom_range(0, 2000) - 1000; c[i] = $urandom_range(0, 2000) - 1000; end
    run_seq(a, zero_vec(), 1'b1, 0, 1'b0, 1'b1, "b2b_first");
    run_seq(c, zero_vec(), 1'b0, 0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    vec_t v, b;
    for (int t = 0; t < 20; t++) begin
      foreach (v[i]) begin
        if (t % 2 == 0) v[i] = $urandom_range(0, 8191) - 4096;
        else            v[i] = $urandom_range(0, 6) - 3;
        b[i] = $urandom_range(0, 8191) - 4096;
      end
      run_seq(v, b, 1'b1, 2, 1'b1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_negative();
    test_stalls();
    test_abort();
    test_reset_mid();
`ifdef BNN_ARGMAX_BIAS_EN
    test_bias();
`endif
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_fc_argmax.md
BNN_FC_ARGMAX -- requirements
Module: bnn_fc_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of FC output neurons consumed per inference, range 2..16.
REQ-002 SHALL have parameter DW, default 13: width of each signed FC accumulator result.
REQ-003 SHALL have parameter CW, default 4: width of the class index, with 2^CW >= NUM_CLASSES.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: iCLK input 1 (rising-edge clock); iRST_n input 1 (asynchronous active-low reset).
REQ-005 SHALL have iSTART input 1: begin a new inference; sampled every cycle.
REQ-006 SHALL have iVALID input 1: iDATA carries the next neuron result, in neuron order 0..NUM_CLASSES-1.
REQ-007 SHALL have iDATA input DW: signed FC accumulator value.
REQ-008 SHALL have iBIAS input DW: signed per-neuron bias aligned with iDATA (present only with BNN_ARGMAX_BIAS_EN).
REQ-009 SHALL have oREADY output 1: a beat is accepted when iVALID and oREADY are both high.
REQ-010 SHALL have oBUSY output 1: high while in the COLLECT state.
REQ-011 SHALL have oDONE output 1: one-cycle pulse when a result is available.
REQ-012 SHALL have oCLASS output CW: index of the winning neuron.
REQ-013 SHALL have oSCORE output DW+1: signed winning score.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT and DONE; transitions are IDLE->COLLECT on iSTART, COLLECT->DONE on the accepted beat with index NUM_CLASSES-1, and DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL hold oREADY=1 only in COLLECT; oREADY SHALL be registered and rise the cycle after iSTART is sampled.
REQ-016 SHALL, on entering COLLECT, clear the neuron counter to 0, set the running max to the most negative (DW+1)-bit value, and set the best index to 0.
REQ-017 SHALL form score = sign-extend(iDATA) to DW+1 bits, plus sign-extend(iBIAS) when the bias feature is enabled; the sum SHALL NOT overflow at DW+1 bits.
REQ-018 SHALL, for each accepted beat, replace max and index only if score > max (strict); ties keep the lower index.
REQ-019 SHALL increment the counter by one per accepted beat; cycles with iVALID low SHALL leave all state unchanged, so stalls of any length are legal.
REQ-020 SHALL register oCLASS/oSCORE from the final comparison and assert oDONE in the DONE cycle; the last beat is accepted at cycle t and oDONE is high at t+1.
REQ-021 SHALL hold oCLASS/oSCORE stable from oDONE until the next oDONE or reset.
REQ-022 SHALL, on iSTART in COLLECT, abort and restart COLLECT initialisation per REQ-016; any beat in the same cycle SHALL be discarded.
REQ-023 SHALL, on iSTART in DONE, still pulse oDONE and then enter COLLECT directly.
REQ-024 SHALL ignore iVALID outside COLLECT, and SHALL accept no beat after the NUM_CLASSES-th.

Reset
REQ-025 SHALL, while iRST_n=0, asynchronously force state=IDLE, counter=0, max and index=0, oREADY=0, oBUSY=0, oDONE=0, oCLASS=0 and oSCORE=0.
REQ-026 SHALL, on reset mid-COLLECT, discard the partial inference and require a new iSTART after release.

Configuration
REQ-027 SHALL, with macro BNN_ARGMAX_BIAS_EN defined, provide the iBIAS port and add it per REQ-017.
REQ-028 SHALL, without BNN_ARGMAX_BIAS_EN, omit the iBIAS port and set score = sign-extend(iDATA); behaviour is otherwise identical.

Structure
REQ-029 SHALL place the FSM state encoding and the NUM_CLASSES/DW/CW defaults in the shared BNN package, and SHALL take the reset-value constant for max as the most negative DW+1 value.
REQ-030 SHALL implement the signed compare-and-select as one sub-module, bnn_max_cmp (inputs: score, index, current max, current index; outputs: next max, next index).

Verification
REQ-031 SHALL verify the basic case: iSTART, then values 5,-3,40,40,7,0,-48,12,1,2 with no stalls -> oDONE at last-beat+1, oCLASS=2, oSCORE=40.
REQ-032 SHALL verify the all-negative case: values -2592 x10 -> oCLASS=0, oSCORE=-2592, which checks the max initialisation and tie rule.
REQ-033 SHALL verify stalls: same data as REQ-031 with iVALID low for 3 cycles between each beat -> identical result, with oREADY continuously high during COLLECT.
REQ-034 SHALL verify abort: iSTART asserted together with the 4th beat, then a full sequence with the maximum 100 at index 9 -> the 4th beat is discarded, one oDONE, oCLASS=9.
REQ-035 SHALL verify reset mid-COLLECT: iRST_n low after 5 beats -> all outputs 0 immediately, and iVALID is ignored until iSTART.
REQ-036 SHALL verify bias (BNN_ARGMAX_BIAS_EN): iDATA 2592 at index 0 with iBIAS 2592, and iDATA 2591 elsewhere with iBIAS 0 -> oSCORE=5184, oCLASS=0, with no overflow.
